add_sub_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one `add_sub` unit among N_REQ requesters.
- The `add_sub` unit is combinational: 3-bit sign-magnitude operands, `selection` 0=add / 1=sub, 5-bit sign-magnitude `result`, `zeroflag`.
- Each requester hands over one operation through a valid/ready handshake. The block instantiates `add_sub`, registers its outputs and returns them with the requester ID on a single response channel.

---
 rtl/add_sub_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_add_sub_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter that shares one combinational sign-magnitude add/sub unit
// among N_REQ requesters and returns registered results on one response channel.

module add_sub (
    input  logic [2:0] num1,
    input  logic [2:0] num2,
    input  logic       selection,
    output logic [4:0] result,
    output logic       zeroflag
);

    function automatic logic signed [3:0] sm3_value(input logic [2:0] sm);
        logic signed [3:0] mag;
        mag = {2'b00, sm[1:0]};
        return sm[2] ? -mag : mag;
    endfunction

    logic signed [3:0] sum_s;
    logic [3:0]        mag_s;

    // Exact result lies in -6..+6, so a 4-bit signed sum cannot overflow
    always_comb begin
        if (selection) begin
            sum_s = sm3_value(num1) - sm3_value(num2);
        end else begin
            sum_s = sm3_value(num1) + sm3_value(num2);
        end
        mag_s    = sum_s[3] ? 4'(-sum_s) : 4'(sum_s);
        result   = {sum_s[3], mag_s};
        zeroflag = (mag_s == 4'd0);
    end

endmodule

module add_sub_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [3*N_REQ-1:0] req_num1,
    input  logic [3*N_REQ-1:0] req_num2,
    input  logic [N_REQ-1:0]   req_sel,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [4:0]         rsp_result,
    output logic               rsp_zero,
    output logic               busy,
    output logic [7:0]         op_count
);

    localparam int IW = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [2:0]        num1_r, num2_r;
    logic              sel_r;
    logic [ID_W-1:0]   id_r;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [4:0]        rsp_result_r;
    logic              rsp_zero_r;
    logic [7:0]        op_count_r;
    logic              busy_r;

    logic [N_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]   gnt_id_s;
    logic              gnt_any_s;
    logic [IW-1:0]     idx_s;
    logic              hit_s;
    logic [2:0]        gnt_num1_s, gnt_num2_s;
    logic              gnt_sel_s;
    logic              transfer_s;
    logic [ID_W-1:0]   rr_next_s;
    logic [4:0]        alu_result_s;
    logic              alu_zero_s;

    // Round-robin scan starting at rr_ptr; first pending requester wins
    always_comb begin
        gnt_s     = '0;
        gnt_id_s  = '0;
        gnt_any_s = 1'b0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = {1'b0, rr_ptr_r} + IW'(k);
            if (idx_s >= IW'(N_REQ)) begin
                idx_s = idx_s - IW'(N_REQ);
            end else begin
                idx_s = idx_s;
            end
            for (int i = 0; i < N_REQ; i++) begin
                hit_s     = !gnt_any_s && (idx_s == IW'(i)) && req_valid[i];
                gnt_s[i]  = gnt_s[i] | hit_s;
                gnt_id_s  = hit_s ? ID_W'(i) : gnt_id_s;
                gnt_any_s = gnt_any_s | hit_s;
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        gnt_num1_s = 3'b000;
        gnt_num2_s = 3'b000;
        gnt_sel_s  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_num1_s = gnt_s[i] ? req_num1[3*i +: 3] : gnt_num1_s;
            gnt_num2_s = gnt_s[i] ? req_num2[3*i +: 3] : gnt_num2_s;
            gnt_sel_s  = gnt_s[i] ? req_sel[i]         : gnt_sel_s;
        end
    end

    // Grant is only visible while idle and out of reset
    always_comb begin
        if ((state_r == IDLE) && !rst) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
        transfer_s = (state_r == IDLE) && gnt_any_s;
        if (gnt_id_s == ID_W'(N_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = gnt_id_s + ID_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = gnt_any_s ? CALC : IDLE;
            CALC:    state_s = RESP;
            RESP:    state_s = rsp_ready ? IDLE : RESP;
            default: state_s = IDLE;
        endcase
    end

    add_sub u_add_sub (
        .num1      (num1_r),
        .num2      (num2_r),
        .selection (sel_r),
        .result    (alu_result_s),
        .zeroflag  (alu_zero_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Operand latch, response registers and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r     <= '0;
            num1_r       <= 3'b000;
            num2_r       <= 3'b000;
            sel_r        <= 1'b0;
            id_r         <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= 5'd0;
            rsp_zero_r   <= 1'b0;
            op_count_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (transfer_s) begin
                        num1_r   <= gnt_num1_s;
                        num2_r   <= gnt_num2_s;
                        sel_r    <= gnt_sel_s;
                        id_r     <= gnt_id_s;
                        rr_ptr_r <= rr_next_s;
                    end
                end
                CALC: begin
                    rsp_result_r <= alu_result_s;
                    rsp_zero_r   <= alu_zero_s;
                    rsp_id_r     <= id_r;
                    rsp_valid_r  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        op_count_r  <= op_count_r + 8'd1;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_zero   = rsp_zero_r;
    assign op_count   = op_count_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Bench for add_sub_arbiter: vector table, scoreboard on the response channel,
// round-robin, backpressure and mid-operation reset sequences.

module tb_add_sub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_num1, req_num2;
    logic [3:0]  req_sel;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_result;
    logic        rsp_zero, busy;
    logic [7:0]  op_count;

    add_sub_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_num1(req_num1),
        .req_num2(req_num2), .req_sel(req_sel), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [2:0] n1;
        logic [2:0] n2;
        logic       sel;
        logic [4:0] res;
        logic       z;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [4:0] res;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    int   cyc = 0;
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model(input logic [2:0] a, input logic [2:0] b, input logic s);
        int va, vb, r;
        va = int'(a[1:0]);
        if (a[2]) va = -va;
        vb = int'(b[1:0]);
        if (b[2]) vb = -vb;
        r = s ? va - vb : va + vb;
        return (r < 0) ? {1'b1, 4'(-r)} : {1'b0, 4'(r)};
    endfunction

    task automatic push(input int id, input logic [4:0] res, input logic z);
        exp_t e;
        e.id = 2'(id);
        e.res = res;
        e.z = z;
        sb.push_back(e);
    endtask

    // Scoreboard: compare every accepted response against the oldest expectation
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_result", 32'(rsp_result), 32'(e.res));
                check("rsp_zero", 32'(rsp_zero), 32'(e.z));
            end
        end
    end

    // Must be called positioned at a negedge; returns with the grant sampled
    task automatic wait_grant(input logic [3:0] exp, input string name, output bit ok);
        int n = 0;
        while (req_ready == 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready != 4'b0000);
        if (!ok) check({name, "_timeout"}, 32'(req_ready), 32'(exp));
        else     check(name, 32'(req_ready), 32'(exp));
    endtask

    task automatic drive(input int id, input logic [2:0] n1, input logic [2:0] n2, input logic s);
        req_num1[3*id +: 3] = n1;
        req_num2[3*id +: 3] = n2;
        req_sel[id] = s;
        req_valid[id] = 1'b1;
    endtask

    // From the grant negedge to the following IDLE negedge, rsp_ready high
    task automatic finish_op(input int id);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        check("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        exp_cnt++;
        check("op_count", 32'(op_count), 32'(exp_cnt));
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_op(input vec_t v);
        bit ok;
        @(posedge clk); #1;
        drive(v.id, v.n1, v.n2, v.sel);
        @(negedge clk);
        wait_grant(4'(1 << v.id), "grant_single", ok);
        if (ok) begin
            check("idle_busy", 32'(busy), 32'd0);
            push(v.id, v.res, v.z);
            finish_op(v.id);
        end else begin
            req_valid = 4'b0000;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int last_cyc;
        vecs[0] = '{0, 3'b011, 3'b111, 1'b0, 5'b00000, 1'b1};
        vecs[1] = '{2, 3'b011, 3'b111, 1'b1, 5'b00110, 1'b0};
        vecs[2] = '{2, 3'b111, 3'b011, 1'b1, 5'b10110, 1'b0};
        vecs[3] = '{1, 3'b100, 3'b000, 1'b0, 5'b00000, 1'b1};
        vecs[4] = '{3, 3'b101, 3'b001, 1'b1, 5'b10010, 1'b0};
        vecs[5] = '{1, 3'b010, 3'b001, 1'b0, 5'b00011, 1'b0};
        vecs[6] = '{3, 3'b110, 3'b011, 1'b0, 5'b00001, 1'b0};
        vecs[7] = '{0, 3'b001, 3'b011, 1'b1, 5'b10010, 1'b0};
        vecs[8] = '{2, 3'b111, 3'b111, 1'b0, 5'b10110, 1'b0};
        vecs[9] = '{0, 3'b100, 3'b100, 1'b1, 5'b00000, 1'b1};

        rst = 1'b1;
        req_valid = 4'b0000;
        req_num1 = 12'd0;
        req_num2 = 12'd0;
        req_sel = 4'b0000;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        for (int v = 0; v < 10; v++) do_op(vecs[v]);

        // Backpressure: response held for 5 cycles while another request waits
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive(1, 3'b010, 3'b001, 1'b1);
        @(negedge clk);
        wait_grant(4'b0010, "bp_grant1", ok);
        push(1, 5'b00001, 1'b0);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drive(3, 3'b111, 3'b100, 1'b0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(rsp_id), 32'd1);
            check("bp_rsp_result", 32'(rsp_result), 32'(5'b00001));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_op_count", 32'(op_count), 32'(exp_cnt));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_cnt++;
        check("bp_op_count_once", 32'(op_count), 32'(exp_cnt));
        wait_grant(4'b1000, "bp_grant3", ok);
        push(3, 5'b10011, 1'b0);
        finish_op(3);

        // Round robin with all four requests held
        pulse_reset();
        for (int k = 0; k < 4; k++) drive(k, 3'(k), 3'b101, k[0]);
        @(negedge clk);
        last_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            if (g > 0) @(negedge clk);
            wait_grant(4'(1 << (g % 4)), "rr_grant", ok);
            if (!ok) break;
            if (g > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            push(g % 4, model(3'(g % 4), 3'b101, 1'((g % 4) & 1)), 1'b0);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check("rr_op_count", 32'(op_count), 32'd5);
        exp_cnt = 5;

        // Reset during CALC discards the operation and rewinds rr_ptr
        @(posedge clk); #1;
        drive(2, 3'b001, 3'b001, 1'b0);
        @(negedge clk);
        wait_grant(4'b0100, "rc_grant2", ok);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid[2] = 1'b0;
        drive(1, 3'b011, 3'b001, 1'b0);
        drive(3, 3'b110, 3'b010, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rc_op_count", 32'(op_count), 32'd0);
        check("rc_busy", 32'(busy), 32'd0);
        check("rc_req_ready_in_rst", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        wait_grant(4'b0010, "rc_grant1_first", ok);
        push(1, 5'b00100, 1'b0);
        finish_op(1);
        wait_grant(4'b1000, "rc_grant3", ok);
        push(3, 5'b10100, 1'b0);
        finish_op(3);

        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
